// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: state encoding, match
// counter width and the tolerance compare helper.
package clk_period_meter_pkg;

  localparam int unsigned ST_W    = 2;
  localparam int unsigned MATCH_W = 8;

  typedef logic [ST_W-1:0] state_t;

  // State encoding, kept numerically identical to the divider benches.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_LOW  = 2'd2;

  // Unsigned |meas - expv| <= tol without any wrap-around.
  function automatic logic in_tol(input logic [31:0] meas,
                                  input logic [31:0] expv,
                                  input logic [31:0] tol);
    logic [31:0] diff;
    diff = (meas >= expv) ? (meas - expv) : (expv - meas);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Control/result bundle between the meter and whatever programs and reads it.
interface clk_period_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sig_in;
  logic             clr;
  logic [CNT_W-1:0] expect_period;
  logic [CNT_W-1:0] expect_high;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             overflow;

  modport master (
    output sig_in, clr, expect_period, expect_high,
    input  period, high_time, meas_valid, locked, overflow
  );

  modport slave (
    input  sig_in, clr, expect_period, expect_high,
    output period, high_time, meas_valid, locked, overflow
  );
endinterface

// File: rtl/clk_period_meter_sync_ff.sv
// Generic multi-flop synchronizer, async reset to 0.
module clk_period_meter_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk cycles and flags
// lock once enough consecutive measurements fall inside tolerance.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned TOL         = 1
) (
  input  logic              clk,
  input  logic              reset,
  clk_period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_CNT);
  localparam logic [31:0]        TOL_V   = 32'(TOL);

  logic s;
  logic s_d;
  logic rise_c;
  logic fall_c;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     hi_reg, hi_reg_nxt;
  logic [CNT_W-1:0]     period_r, period_nxt;
  logic [CNT_W-1:0]     high_time_r, high_time_nxt;
  logic                 meas_valid_r, meas_valid_nxt;
  logic                 locked_r, locked_nxt;
  logic                 overflow_r, overflow_nxt;
  logic [MATCH_W-1:0]   match_cnt, match_cnt_nxt;
  logic                 match_c;
  logic [MATCH_W-1:0]   match_inc_c;

  clk_period_meter_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ff (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sig_in),
    .q     (s)
  );

  assign rise_c = s & ~s_d;
  assign fall_c = ~s & s_d;

  // The measurement being closed by a rise is (cnt, hi_reg).
  assign match_c = in_tol(32'(cnt), 32'(bus.expect_period), TOL_V) &&
                   in_tol(32'(hi_reg), 32'(bus.expect_high), TOL_V);
  assign match_inc_c = (match_cnt >= LOCK_V) ? LOCK_V : (match_cnt + MATCH_W'(1));

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      s_d          <= 1'b0;
      cnt          <= '0;
      hi_reg       <= '0;
      period_r     <= '0;
      high_time_r  <= '0;
      meas_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      overflow_r   <= 1'b0;
      match_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      s_d          <= s;
      cnt          <= cnt_nxt;
      hi_reg       <= hi_reg_nxt;
      period_r     <= period_nxt;
      high_time_r  <= high_time_nxt;
      meas_valid_r <= meas_valid_nxt;
      locked_r     <= locked_nxt;
      overflow_r   <= overflow_nxt;
      match_cnt    <= match_cnt_nxt;
    end
  end

  // Next-state, counter, measurement and lock logic; clr overrides edges.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = rise_c ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE));
    hi_reg_nxt     = hi_reg;
    period_nxt     = period_r;
    high_time_nxt  = high_time_r;
    meas_valid_nxt = 1'b0;
    locked_nxt     = locked_r;
    overflow_nxt   = overflow_r;
    match_cnt_nxt  = match_cnt;

    if (bus.clr) begin
      state_nxt     = ST_IDLE;
      cnt_nxt       = '0;
      hi_reg_nxt    = '0;
      period_nxt    = '0;
      high_time_nxt = '0;
      locked_nxt    = 1'b0;
      overflow_nxt  = 1'b0;
      match_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise_c) state_nxt = ST_HIGH;
        end
        ST_HIGH: begin
          if (cnt == CNT_MAX) begin
            overflow_nxt  = 1'b1;
            locked_nxt    = 1'b0;
            match_cnt_nxt = '0;
            state_nxt     = ST_IDLE;
          end else if (fall_c) begin
            hi_reg_nxt = cnt;
            state_nxt  = ST_LOW;
          end
        end
        ST_LOW: begin
          // A rise coinciding with saturation still closes the period.
          if (rise_c) begin
            period_nxt     = cnt;
            high_time_nxt  = hi_reg;
            meas_valid_nxt = 1'b1;
            state_nxt      = ST_HIGH;
            if (match_c) begin
              match_cnt_nxt = match_inc_c;
              locked_nxt    = (match_inc_c == LOCK_V);
            end else begin
              match_cnt_nxt = '0;
              locked_nxt    = 1'b0;
            end
          end else if (cnt == CNT_MAX) begin
            overflow_nxt  = 1'b1;
            locked_nxt    = 1'b0;
            match_cnt_nxt = '0;
            state_nxt     = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.period     = period_r;
  assign bus.high_time  = high_time_r;
  assign bus.meas_valid = meas_valid_r;
  assign bus.locked     = locked_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a 16-bit meter driven by directed and random
// waveforms against an edge-timing reference model, and a 4-bit meter used
// for the saturation scenario.
module tb_clk_period_meter;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SCNT_W = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned LOCKN  = 4;
  localparam int unsigned TOL    = 1;
  // Edge launched at a negedge: SYNC capture edges, then one edge to register
  // the result. An edge landing just after a posedge costs one more cycle.
  localparam int LAT = int'(SYNC) + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(CNT_W))  bus ();
  clk_period_meter_if #(.CNT_W(SCNT_W)) sbus ();

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCKN), .TOL(TOL)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  clk_period_meter #(.CNT_W(SCNT_W), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCKN), .TOL(TOL)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  typedef struct {
    int per;
    int hi;
    int due;
  } meas_t;

  meas_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    stepn = 0;
  bit    armed = 1'b0;
  int    last_rise = 0;
  int    last_fall = 0;
  int    mcnt = 0;
  bit    exp_locked = 1'b0;
  int    exp_per = 0;
  int    exp_hi = 0;
  int    ep = 6;
  int    eh = 3;
  int    main_mv = 0;
  int    lock_at = 0;
  int    sm_mv = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic set_expect(input int p, input int h);
    ep = p;
    eh = h;
    bus.expect_period = CNT_W'(p);
    bus.expect_high   = CNT_W'(h);
  endtask

  task automatic model_clear();
    q.delete();
    armed      = 1'b0;
    mcnt       = 0;
    exp_locked = 1'b0;
    exp_per    = 0;
    exp_hi     = 0;
  endtask

  // Per-cycle comparison of the 16-bit meter against the model.
  task automatic check_all();
    bit    mv_exp;
    bit    match;
    meas_t m;
    while (q.size() > 0 && q[0].due < stepn) void'(q.pop_front());
    mv_exp = (q.size() > 0) && (q[0].due == stepn);
    chk("meas_valid", 32'(bus.meas_valid), 32'(mv_exp));
    if (bus.meas_valid === 1'b1) main_mv++;
    if (mv_exp) begin
      m = q.pop_front();
      match = (iabs(m.per - ep) <= int'(TOL)) && (iabs(m.hi - eh) <= int'(TOL));
      mcnt = match ? ((mcnt < int'(LOCKN)) ? mcnt + 1 : int'(LOCKN)) : 0;
      exp_locked = (mcnt == int'(LOCKN));
      exp_per = m.per;
      exp_hi  = m.hi;
    end
    chk("period", 32'(bus.period), 32'(exp_per));
    chk("high_time", 32'(bus.high_time), 32'(exp_hi));
    chk("locked", 32'(bus.locked), 32'(exp_locked));
    chk("overflow", 32'(bus.overflow), 32'd0);
    if (lock_at == 0 && bus.locked === 1'b1) lock_at = main_mv;
    if (sbus.meas_valid === 1'b1) begin
      sm_mv++;
      chk("s_period", 32'(sbus.period), 32'd6);
      chk("s_high", 32'(sbus.high_time), 32'd3);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    stepn++;
    check_all();
  endtask

  // mode 0: drive at negedge; 1: just before posedge; 2: just after posedge.
  task automatic seg(input logic lvl, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0 && bus.sig_in !== lvl) begin
        int eff;
        eff = stepn + ((mode == 2) ? 1 : 0);
        if (lvl) begin
          if (armed) q.push_back('{per: eff - last_rise, hi: last_fall - last_rise, due: eff + LAT});
          armed = 1'b1;
          last_rise = eff;
        end else begin
          last_fall = eff;
        end
        if (mode == 1) #4;
        else if (mode == 2) #6;
        bus.sig_in = lvl;
      end
    end
  endtask

  task automatic period_hl(input int h, input int l, input int mode);
    seg(1'b1, h, mode);
    seg(1'b0, l, mode);
  endtask

  task automatic sseg(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) sbus.sig_in = lvl;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at step %0d", stepn);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset = 1'b1;
    bus.sig_in = 1'b0;
    bus.clr = 1'b0;
    set_expect(6, 3);
    sbus.sig_in = 1'b0;
    sbus.clr = 1'b0;
    sbus.expect_period = SCNT_W'(6);
    sbus.expect_high   = SCNT_W'(3);

    // Reset state
    tick();
    tick();
    chk("rst_s_overflow", 32'(sbus.overflow), 32'd0);
    chk("rst_s_locked", 32'(sbus.locked), 32'd0);
    reset = 1'b0;

    // 3 high / 3 low, expect 6/3: lock on the 4th measurement
    lock_at = 0;
    main_mv = 0;
    repeat (8) period_hl(3, 3, 0);
    chk("t1_locked", 32'(bus.locked), 32'd1);
    chk("t1_lock_at", 32'(lock_at), 32'd4);
    chk("t1_meas_count", 32'(main_mv), 32'd7);

    // One stretched period (period 8) breaks lock, four good ones restore it
    period_hl(3, 5, 0);
    period_hl(3, 3, 0);
    chk("t2_unlocked", 32'(bus.locked), 32'd0);
    chk("t2_bad_period", 32'(bus.period), 32'd8);
    repeat (4) period_hl(3, 3, 0);
    chk("t2_relocked", 32'(bus.locked), 32'd1);

    // Divide-by-3 pattern, then an expectation change inside tolerance
    set_expect(3, 2);
    repeat (6) period_hl(2, 1, 0);
    chk("t3_locked", 32'(bus.locked), 32'd1);
    chk("t3_period", 32'(bus.period), 32'd3);
    chk("t3_high", 32'(bus.high_time), 32'd2);
    set_expect(4, 2);
    repeat (2) period_hl(2, 1, 0);
    chk("t3_history_kept", 32'(bus.locked), 32'd1);

    // Random periods around 4/6 with random edge placement
    set_expect(10, 4);
    repeat (30) begin
      if ($urandom_range(1, 0) == 1)
        period_hl(4, 6, int'($urandom_range(1, 0)));
      else
        period_hl(int'($urandom_range(7, 1)), int'($urandom_range(9, 1)), int'($urandom_range(1, 0)));
    end

    // Edges jittered by up to one cycle stay within tolerance
    set_expect(12, 5);
    repeat (12) period_hl(5, 7, int'($urandom_range(2, 0)));
    chk("t6_jitter_locked", 32'(bus.locked), 32'd1);
    seg(1'b0, 6, 0);

    // Clear while locked; first rise afterwards only arms
    tick();
    bus.clr = 1'b1;
    model_clear();
    tick();
    bus.clr = 1'b0;
    chk("t5_clr_locked", 32'(bus.locked), 32'd0);
    chk("t5_clr_period", 32'(bus.period), 32'd0);
    snap = main_mv;
    period_hl(3, 3, 0);
    seg(1'b0, 6, 0);
    chk("t5_no_meas", 32'(main_mv - snap), 32'd0);
    set_expect(6, 3);
    repeat (6) period_hl(3, 3, 0);
    chk("t5_relocked", 32'(bus.locked), 32'd1);

    // Reset in the middle of a low phase
    seg(1'b1, 3, 0);
    seg(1'b0, 2, 0);
    tick();
    #1 reset = 1'b1;
    #1;
    model_clear();
    chk("t6_rst_period", 32'(bus.period), 32'd0);
    chk("t6_rst_high", 32'(bus.high_time), 32'd0);
    chk("t6_rst_locked", 32'(bus.locked), 32'd0);
    chk("t6_rst_valid", 32'(bus.meas_valid), 32'd0);
    tick();
    reset = 1'b0;
    seg(1'b0, 3, 0);
    repeat (6) period_hl(3, 3, 0);
    chk("t6_relocked", 32'(bus.locked), 32'd1);
    chk("t6_period", 32'(bus.period), 32'd6);

    // 4-bit meter: lock, saturate while held high, resume, then clear
    sm_mv = 0;
    chk("t4_idle_no_ovf", 32'(sbus.overflow), 32'd0);
    repeat (6) begin
      sseg(1'b1, 3);
      sseg(1'b0, 3);
    end
    chk("t4_locked", 32'(sbus.locked), 32'd1);
    chk("t4_meas5", 32'(sm_mv), 32'd5);
    sseg(1'b1, 20);
    chk("t4_overflow", 32'(sbus.overflow), 32'd1);
    chk("t4_unlocked", 32'(sbus.locked), 32'd0);
    chk("t4_meas6", 32'(sm_mv), 32'd6);
    sseg(1'b0, 3);
    repeat (4) begin
      sseg(1'b1, 3);
      sseg(1'b0, 3);
    end
    chk("t4_meas9", 32'(sm_mv), 32'd9);
    chk("t4_ovf_sticky", 32'(sbus.overflow), 32'd1);
    chk("t4_not_relocked", 32'(sbus.locked), 32'd0);
    tick();
    sbus.clr = 1'b1;
    tick();
    sbus.clr = 1'b0;
    chk("t4_clr_ovf", 32'(sbus.overflow), 32'd0);
    chk("t4_clr_period", 32'(sbus.period), 32'd0);
    chk("t4_clr_high", 32'(sbus.high_time), 32'd0);

    seg(1'b0, 6, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
